// File: rtl/mul_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative radix-2 RV32M multiply/divide unit driving the
//            register-file write port with a one-cycle result pulse.
// Revision : 1.0
// ============================================================================
module mul_div_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  logic [RADDR_W-1:0] rd,
    input  logic               kill,
    output logic               busy,
    output logic [RADDR_W-1:0] busy_rd,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]    wb_data
);

    localparam int C_CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [RADDR_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]      a_q, a_d;
    logic [XLEN-1:0]      opnd_q, opnd_d;
    logic [2*XLEN-1:0]    prod_q, prod_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 bzero_q, bzero_d;
    logic [RADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]      wb_data_q, wb_data_d;

    logic                 w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]      w_mag_a, w_mag_b;
    logic [XLEN:0]        w_mul_sum;
    logic [XLEN:0]        w_div_shift, w_div_diff;
    logic                 w_div_ge;
    logic [2*XLEN-1:0]    w_prod_neg;
    logic [XLEN-1:0]      w_hi, w_lo, w_result;

    assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign w_a_neg    = w_a_signed & a[XLEN-1];
    assign w_b_neg    = w_b_signed & b[XLEN-1];
    assign w_mag_a    = w_a_neg ? (~a + 1'b1) : a;
    assign w_mag_b    = w_b_neg ? (~b + 1'b1) : b;

    // Multiply: low half of prod_q holds the shrinking multiplier, high half accumulates.
    assign w_mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    assign w_div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, opnd_q};
    assign w_div_ge    = ~w_div_diff[XLEN];

    assign w_prod_neg = ~prod_q + 1'b1;
    assign w_hi       = prod_q[2*XLEN-1:XLEN];
    assign w_lo       = prod_q[XLEN-1:0];

    always_comb begin
        w_result = w_lo;
        case (op_q)
            3'b000:                 w_result = w_lo;
            3'b001, 3'b010, 3'b011: w_result = neg_q ? w_prod_neg[2*XLEN-1:XLEN] : w_hi;
            3'b100, 3'b101:         w_result = bzero_q ? '1 : (neg_q ? (~w_lo + 1'b1) : w_lo);
            default:                w_result = bzero_q ? a_q : (neg_q ? (~w_hi + 1'b1) : w_hi);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        a_d       = a_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        bzero_d   = bzero_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !kill) begin
                    state_d = CALC;
                    op_d    = op;
                    rd_d    = rd;
                    a_d     = a;
                    cnt_d   = '0;
                    bzero_d = (b == '0);
                    if (op[2]) begin
                        opnd_d = w_mag_b;
                        prod_d = {{XLEN{1'b0}}, w_mag_a};
                        neg_d  = op[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
                    end else begin
                        opnd_d = w_mag_a;
                        prod_d = {{XLEN{1'b0}}, w_mag_b};
                        neg_d  = w_a_neg ^ w_b_neg;
                    end
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    prod_d = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                              prod_q[XLEN-2:0], w_div_ge};
                end else begin
                    prod_d = {w_mul_sum, prod_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_CNT_W'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                wb_data_d = w_result;
                wb_addr_d = rd_q;
                state_d   = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Flush wins over everything, including the FIX-cycle result latch.
        if (kill && (state_q != IDLE)) begin
            state_d   = IDLE;
            wb_data_d = wb_data_q;
            wb_addr_d = wb_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            bzero_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            bzero_q   <= bzero_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign busy_rd  = busy ? rd_q : '0;
    assign wb_we    = (state_q == DONE) && (rd_q != '0) && !kill;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Directed vector table plus hand-written flush/reset/stall sequences.
// Revision : 1.0
// ============================================================================
module tb_mul_div_unit;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    // DONE is entered at edge E0+XLEN+1, so the pulse occupies the XLEN+2'th cycle.
    localparam int C_WE_EDGE = XLEN + 1;
    localparam int C_NVEC    = 20;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [2:0]         op = 3'b000;
    logic [XLEN-1:0]    a = '0;
    logic [XLEN-1:0]    b = '0;
    logic [RADDR_W-1:0] rd = '0;
    logic               kill = 1'b0;
    logic               busy;
    logic [RADDR_W-1:0] busy_rd;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]    wb_data;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .rd(rd), .kill(kill), .busy(busy), .busy_rd(busy_rd),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[C_NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at the negedge following the accepting edge E0, with in_valid dropped.
    task automatic start_op(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                            input logic [4:0] rd_v);
        @(negedge clk);
        in_valid = 1'b1; op = op_v; a = a_v; b = b_v; rd = rd_v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [4:0] rd_v, output logic [31:0] data_o,
                          output logic [4:0] addr_o, output int lat_o, output int pulses_o,
                          output bit busy_ok_o);
        start_op(op_v, a_v, b_v, rd_v);
        lat_o = -1; pulses_o = 0; busy_ok_o = 1'b1; data_o = '0; addr_o = '0;
        for (int j = 0; j < 60; j++) begin
            if (j > 0) @(negedge clk);
            if (j <= C_WE_EDGE && (!busy || busy_rd !== rd_v || in_ready)) busy_ok_o = 1'b0;
            if (wb_we) begin
                pulses_o++;
                if (lat_o < 0) begin
                    lat_o = j; data_o = wb_data; addr_o = wb_addr;
                end
            end
            if (j > C_WE_EDGE && !busy) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] data, saved;
        logic [4:0]  addr;
        int          lat, pulses, seen;
        bit          ok;
        logic [4:0]  rdv;

        vecs[0]  = '{3'b000, 32'd7,         32'd6,         32'd42};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'b101, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF};
        vecs[7]  = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[8]  = '{3'b110, 32'd5,         32'd0,         32'd5};
        vecs[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vecs[11] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[12] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
        vecs[13] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        vecs[14] = '{3'b001, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF};
        vecs[15] = '{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        vecs[16] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[17] = '{3'b111, 32'd100,       32'd7,         32'd2};
        vecs[18] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[19] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1};

        repeat (3) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset busy",     64'(busy),     64'd0);
        chk("reset busy_rd",  64'(busy_rd),  64'd0);
        chk("reset wb_we",    64'(wb_we),    64'd0);
        chk("reset wb_addr",  64'(wb_addr),  64'd0);
        chk("reset wb_data",  64'(wb_data),  64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < C_NVEC; i++) begin
            rdv = (i == 0) ? 5'd5 : 5'((i % 31) + 1);
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, rdv, data, addr, lat, pulses, ok);
            chk($sformatf("vec%0d data", i),    64'(data),   64'(vecs[i].exp));
            chk($sformatf("vec%0d addr", i),    64'(addr),   64'(rdv));
            chk($sformatf("vec%0d latency", i), 64'(lat),    64'(C_WE_EDGE));
            chk($sformatf("vec%0d pulses", i),  64'(pulses), 64'd1);
            chk($sformatf("vec%0d busy", i),    64'(ok),     64'd1);
        end

        // rd=0 op with in_valid held: second op waits for IDLE, no write for the first.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4; rd = 5'd0;
        @(negedge clk);
        a = 32'd5; b = 32'd3; rd = 5'd7;
        ok = 1'b1; seen = 0;
        for (int j = 0; j <= C_WE_EDGE; j++) begin
            if (j > 0) @(negedge clk);
            if (in_ready || !busy || busy_rd !== 5'd0) ok = 1'b0;
            if (wb_we) seen++;
        end
        chk("hold stall", 64'(ok), 64'd1);
        chk("rd0 no wb_we", 64'(seen), 64'd0);
        @(negedge clk);
        chk("hold idle in_ready", 64'(in_ready), 64'd1);
        chk("hold idle busy", 64'(busy), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("second accept busy", 64'(busy), 64'd1);
        chk("second accept busy_rd", 64'(busy_rd), 64'd7);
        lat = -1;
        for (int j = 0; j < 50; j++) begin
            if (j > 0) @(negedge clk);
            if (wb_we && lat < 0) begin
                lat = j; data = wb_data; addr = wb_addr;
            end
            if (j > C_WE_EDGE && !busy) break;
        end
        chk("second latency", 64'(lat), 64'(C_WE_EDGE));
        chk("second data", 64'(data), 64'd15);
        chk("second addr", 64'(addr), 64'd7);

        // Kill during CALC.
        saved = wb_data;
        start_op(3'b000, 32'd9, 32'd9, 5'd3);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill calc busy", 64'(busy), 64'd0);
        chk("kill calc in_ready", 64'(in_ready), 64'd1);
        chk("kill calc busy_rd", 64'(busy_rd), 64'd0);
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (wb_we) seen++;
        end
        chk("kill calc no wb_we", 64'(seen), 64'd0);
        chk("kill calc wb_data held", 64'(wb_data), 64'(saved));

        // Kill in DONE suppresses the same-cycle write.
        start_op(3'b111, 32'd100, 32'd7, 5'd9);
        repeat (C_WE_EDGE) @(negedge clk);
        chk("done state busy", 64'(busy), 64'd1);
        kill = 1'b1;
        #1;
        chk("kill done wb_we", 64'(wb_we), 64'd0);
        @(negedge clk);
        kill = 1'b0;
        chk("kill done busy", 64'(busy), 64'd0);
        seen = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (wb_we) seen++;
        end
        chk("kill done no wb_we", 64'(seen), 64'd0);

        // Reset mid-CALC.
        start_op(3'b100, 32'd50, 32'd5, 5'd12);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst busy",     64'(busy),     64'd0);
        chk("midrst busy_rd",  64'(busy_rd),  64'd0);
        chk("midrst wb_we",    64'(wb_we),    64'd0);
        chk("midrst wb_addr",  64'(wb_addr),  64'd0);
        chk("midrst wb_data",  64'(wb_data),  64'd0);
        reset_n = 1'b1;

        run_op(3'b000, 32'd7, 32'd6, 5'd5, data, addr, lat, pulses, ok);
        chk("post reset data", 64'(data), 64'd42);
        chk("post reset latency", 64'(lat), 64'(C_WE_EDGE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
